// File: rtl/mux_n_pipe_if.sv
// Handshake and data bundle for mux_n_pipe: upstream beat (sources, selects,
// mask) in, one registered vector operand out.
interface mux_n_pipe_if #(
  parameter int WIDTH  = 24,
  parameter int LANES  = 4,
  parameter int NUM_IN = 3
);
  localparam int SEL_W = ($clog2(NUM_IN) < 1) ? 1 : $clog2(NUM_IN);

  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_IN*LANES*WIDTH-1:0] d_in;
  logic [LANES*SEL_W-1:0]        sel;
  logic [LANES-1:0]              lane_mask;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*WIDTH-1:0]        out_data;

  modport master (
    output in_valid, d_in, sel, lane_mask, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, d_in, sel, lane_mask, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mux_n_pipe.sv
// Registered N-input, multi-lane operand-select mux with a one-deep valid/ready stage.
// Optional sticky out-of-range select flag enabled by defining MUXN_SEL_ERR_EN.
module mux_n_pipe #(
  parameter int WIDTH  = 24,
  parameter int LANES  = 4,
  parameter int NUM_IN = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_n_pipe_if.slave      bus,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             sel_err,
  input  logic             err_clr
);
  localparam int SEL_W = ($clog2(NUM_IN) < 1) ? 1 : $clog2(NUM_IN);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                   state_reg, state_next;
  logic [LANES*WIDTH-1:0]   data_reg, data_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [LANES*WIDTH-1:0]   lane_sel_data;
  logic [LANES-1:0]         lane_oor;
  logic                     accept;

  assign bus.in_ready  = (state_reg == EMPTY) || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_reg == FULL);
  assign bus.out_data  = data_reg;
  assign xfer_cnt      = cnt_reg;

  // Per-lane source select; a code with no matching source is out of range and yields zero.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [SEL_W-1:0] lane_code;
      logic [WIDTH-1:0] lane_val;
      logic             lane_hit;

      assign lane_code = bus.sel[gi*SEL_W +: SEL_W];

      always_comb begin
        lane_val = '0;
        lane_hit = 1'b0;
        for (int s = 0; s < NUM_IN; s++) begin
          if (lane_code == SEL_W'(s)) begin
            lane_val = bus.d_in[(s*LANES+gi)*WIDTH +: WIDTH];
            lane_hit = 1'b1;
          end
        end
      end

      assign lane_sel_data[gi*WIDTH +: WIDTH] = bus.lane_mask[gi] ? lane_val : '0;
      assign lane_oor[gi] = bus.lane_mask[gi] && !lane_hit;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      EMPTY: if (accept) state_next = FULL;
      FULL:  if (bus.out_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
    if (accept) begin
      data_next = lane_sel_data;
      cnt_next  = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      data_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
    end
  end

`ifdef MUXN_SEL_ERR_EN
  logic sel_err_reg, sel_err_next;

  // A new error in the same cycle as a clear must survive the clear.
  always_comb begin
    sel_err_next = sel_err_reg;
    if (err_clr) sel_err_next = 1'b0;
    if (accept && (|lane_oor)) sel_err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_reg <= 1'b0;
    else        sel_err_reg <= sel_err_next;
  end

  assign sel_err = sel_err_reg;
`else
  logic unused_err;
  assign unused_err = err_clr ^ (|lane_oor);
  assign sel_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboarded bench for mux_n_pipe: accepted beats are modelled on entry and
// compared when the output handshake completes; scenario tasks check timing points.
module tb_mux_n_pipe;
  localparam int WIDTH  = 24;
  localparam int LANES  = 4;
  localparam int NUM_IN = 3;
  localparam int CNT_W  = 16;
`ifdef MUXN_SEL_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] xfer_cnt;
  logic             sel_err;

  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  logic [95:0] sb[$];
  logic [95:0] sb_exp;

  mux_n_pipe_if #(.WIDTH(WIDTH), .LANES(LANES), .NUM_IN(NUM_IN)) bus ();

  mux_n_pipe #(.WIDTH(WIDTH), .LANES(LANES), .NUM_IN(NUM_IN), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .xfer_cnt (xfer_cnt),
    .sel_err  (sel_err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] model(input logic [287:0] d, input logic [7:0] s,
                                        input logic [3:0] m);
    logic [95:0] r = '0;
    for (int l = 0; l < LANES; l++) begin
      int c;
      c = int'(s[l*2 +: 2]);
      if (m[l] && c < NUM_IN) r[l*24 +: 24] = d[(c*LANES+l)*24 +: 24];
    end
    return r;
  endfunction

  function automatic logic [287:0] fill();
    logic [287:0] d = '0;
    for (int s = 0; s < NUM_IN; s++)
      for (int l = 0; l < LANES; l++)
        d[(s*LANES+l)*24 +: 24] = 24'(256*s + l);
    return d;
  endfunction

  // Scoreboard: pop/compare on the output handshake, push the modelled beat on accept.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        errors++;
        $display("FAIL in_ready: got %b expected %b", bus.in_ready, !bus.out_valid || bus.out_ready);
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_pop: unexpected beat out_data=%h expected none", bus.out_data);
        end else begin
          sb_exp = sb.pop_front();
          if (bus.out_data !== sb_exp) begin
            errors++;
            $display("FAIL sb_data: got %h expected %h", bus.out_data, sb_exp);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.d_in, bus.sel, bus.lane_mask));
        exp_cnt = (exp_cnt + 1) % 65536;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.sel = '0; bus.lane_mask = '0;
    bus.d_in = fill();
    #2 rst_n = 1'b0;
    #10;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || xfer_cnt !== '0 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b data=%h cnt=%h err=%b expected 0,0,0,0",
               bus.out_valid, bus.out_data, xfer_cnt, sel_err);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus.sel = 8'hAA; bus.lane_mask = 4'hF; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== {24'h203, 24'h202, 24'h201, 24'h200}) begin
      errors++;
      $display("FAIL basic_data: got valid=%b data=%h expected 1 %h", bus.out_valid,
               bus.out_data, {24'h203, 24'h202, 24'h201, 24'h200});
    end
    checks++;
    if (xfer_cnt !== 16'd1) begin
      errors++;
      $display("FAIL basic_cnt: got %h expected 0001", xfer_cnt);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: got valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_sel_range();
    bus.sel = 8'b11_10_01_00; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_data !== {24'h000, 24'h202, 24'h101, 24'h000}) begin
      errors++;
      $display("FAIL range_data: got %h expected %h", bus.out_data,
               {24'h000, 24'h202, 24'h101, 24'h000});
    end
    checks++;
    if (sel_err !== ERR_EN) begin
      errors++;
      $display("FAIL range_err_set: got %b expected %b", sel_err, ERR_EN);
    end
    repeat (3) tick();
    checks++;
    if (sel_err !== ERR_EN) begin
      errors++;
      $display("FAIL range_err_sticky: got %b expected %b", sel_err, ERR_EN);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (sel_err !== 1'b0) begin
      errors++;
      $display("FAIL range_err_clr: got %b expected 0", sel_err);
    end
    bus.in_valid = 1'b1; err_clr = 1'b1;
    tick();
    bus.in_valid = 1'b0; err_clr = 1'b0;
    checks++;
    if (sel_err !== ERR_EN) begin
      errors++;
      $display("FAIL range_set_wins: got %b expected %b", sel_err, ERR_EN);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
  endtask

  task automatic test_mask();
    bus.lane_mask = 4'b0101; bus.sel = 8'h55; bus.in_valid = 1'b1;
    tick();
    bus.sel = 8'b11_01_11_01;
    checks++;
    if (bus.out_data !== {24'h000, 24'h102, 24'h000, 24'h100}) begin
      errors++;
      $display("FAIL mask_data: got %h expected %h", bus.out_data,
               {24'h000, 24'h102, 24'h000, 24'h100});
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_data !== {24'h000, 24'h102, 24'h000, 24'h100} || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL mask_oor: got data=%h err=%b expected %h 0", bus.out_data, sel_err,
               {24'h000, 24'h102, 24'h000, 24'h100});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cnt0;
    bus.lane_mask = 4'hF; bus.sel = 8'hAA; bus.d_in = fill();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    tick();
    cnt0 = exp_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.sel = 8'($urandom()); bus.lane_mask = 4'($urandom());
      bus.d_in = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || xfer_cnt !== 16'(cnt0) ||
          bus.out_data !== {24'h203, 24'h202, 24'h201, 24'h200}) begin
        errors++;
        $display("FAIL stall_%0d: got rdy=%b vld=%b cnt=%h data=%h expected 0 1 %h %h", i,
                 bus.in_ready, bus.out_valid, xfer_cnt, bus.out_data, 16'(cnt0),
                 {24'h203, 24'h202, 24'h201, 24'h200});
      end
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (xfer_cnt !== 16'(cnt0 + i + 1) || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: got cnt=%h vld=%b expected %h 1", i, xfer_cnt,
                 bus.out_valid, 16'(cnt0 + i + 1));
      end
      bus.sel = 8'($urandom()); bus.lane_mask = 4'($urandom());
      bus.d_in = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    int n;
    bus.d_in = fill(); bus.sel = 8'hAA; bus.lane_mask = 4'hF; bus.out_ready = 1'b1;
    n = 65535 - exp_cnt;
    bus.in_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    checks++;
    if (xfer_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_max: got %h expected ffff", xfer_cnt);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (xfer_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero: got %h expected 0000", xfer_cnt);
    end
    tick();
  endtask

  task automatic test_async_reset();
    bus.d_in = fill(); bus.sel = 8'hAA; bus.lane_mask = 4'hF;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_full: got vld=%b expected 1", bus.out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || xfer_cnt !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_now: got vld=%b data=%h cnt=%h rdy=%b expected 0 0 0 1",
               bus.out_valid, bus.out_data, xfer_cnt, bus.in_ready);
    end
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    bus.sel = 8'b01_00_10_01; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || xfer_cnt !== 16'd1 ||
        bus.out_data !== {24'h103, 24'h002, 24'h201, 24'h100}) begin
      errors++;
      $display("FAIL areset_first: got vld=%b cnt=%h data=%h expected 1 0001 %h",
               bus.out_valid, xfer_cnt, bus.out_data, {24'h103, 24'h002, 24'h201, 24'h100});
    end
    tick();
  endtask

  task automatic test_drain();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got vld=%b pending=%0d expected 0 0", bus.out_valid, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sel_range();
    test_mask();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
